// File: rtl/camera_pattern_gen_if.sv
// camera_pattern_gen_if: parallel camera bus (pclk, vsync, href, 8-bit data)
interface camera_pattern_gen_if;
  logic       cam_pclk;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_dout;
  modport master (output cam_pclk, cam_vsync, cam_href, cam_dout);
  modport slave  (input  cam_pclk, cam_vsync, cam_href, cam_dout);
endinterface

// File: rtl/camera_pattern_gen.sv
// camera_pattern_gen: synthetic parallel-camera source emitting RGB565 test frames
module camera_pattern_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic [1:0]                 pattern_sel,
  input  logic [15:0]                solid_rgb,
  output logic                       frame_done,
  output logic [15:0]                frame_count,
  camera_pattern_gen_if.master       cam
);
  localparam int L     = 2 * H_ACTIVE + H_BLANK;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [7:0][15:0] BARS = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                       16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t      state_q, state_d;
  logic        pclk_q, pclk_d;
  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic [10:0] bar_pix_q, bar_pix_d;
  logic [2:0]  bar_q, bar_d;
  logic [1:0]  pat_q, pat_d;
  logic [15:0] solid_q, solid_d;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic [7:0]  dout_q, dout_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [9:0]  last_line;
  logic [15:0] pix;

  assign last_line = state_q == VSYNC  ? 10'(VSYNC_LINES - 1) :
                     state_q == VBACK  ? 10'(V_BACK - 1) :
                     state_q == ACTIVE ? 10'(V_ACTIVE - 1) : 10'(V_FRONT - 1);

  // Frame sequencing, slot/line counters, bar tracking and per-frame pattern latch; all advance on slot edges
  always_comb begin
    state_d       = state_q;
    pclk_d        = ~pclk_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    bar_pix_d     = bar_pix_q;
    bar_d         = bar_q;
    pat_d         = pat_q;
    solid_d       = solid_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    if (pclk_q && state_q == IDLE) begin
      state_d = enable ? VSYNC : IDLE;
    end else if (pclk_q && hcount_q == 11'(L - 1)) begin
      hcount_d = '0;
      vcount_d = vcount_q + 10'd1;
      if (vcount_q == last_line) begin
        vcount_d = '0;
        state_d  = state_q == VSYNC  ? VBACK :
                   state_q == VBACK  ? ACTIVE :
                   state_q == ACTIVE ? VFRONT : (enable ? VSYNC : IDLE);
        if (state_q == VFRONT) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
    end else if (pclk_q) begin
      hcount_d = hcount_q + 11'd1;
    end
    if (pclk_q && state_d == VSYNC && state_q != VSYNC) begin
      pat_d   = pattern_sel;
      solid_d = solid_rgb;
    end
    if (pclk_q && hcount_d == '0) begin
      bar_pix_d = '0;
      bar_d     = '0;
    end else if (pclk_q && hcount_q[0]) begin
      bar_pix_d = bar_pix_q == 11'(BAR_W - 1) ? '0 : bar_pix_q + 11'd1;
      bar_d     = bar_pix_q == 11'(BAR_W - 1) ? bar_q + 3'd1 : bar_q;
    end
  end

  // Pixel colour for the upcoming slot from the frame's latched pattern
  always_comb begin
    pix = pat_d == 2'd0 ? BARS[bar_d] :
          pat_d == 2'd1 ? {hcount_d[8:4], hcount_d[8:3], hcount_d[8:4]} :
          pat_d == 2'd2 ? {16{hcount_d[4] ^ vcount_d[3]}} : solid_d;
  end

  // Bus outputs are recomputed only on slot edges so they hold across the pclk rise
  always_comb begin
    vsync_d = vsync_q;
    href_d  = href_q;
    dout_d  = dout_q;
    if (pclk_q) begin
      vsync_d = state_d == VSYNC;
      href_d  = state_d == ACTIVE && hcount_d < 11'(2 * H_ACTIVE);
      dout_d  = href_d ? (hcount_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    end
  end

  // State and registered outputs, cleared immediately by resetn
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      pclk_q        <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      bar_pix_q     <= '0;
      bar_q         <= '0;
      pat_q         <= '0;
      solid_q       <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      dout_q        <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pclk_q        <= pclk_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      bar_pix_q     <= bar_pix_d;
      bar_q         <= bar_d;
      pat_q         <= pat_d;
      solid_q       <= solid_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      dout_q        <= dout_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign cam.cam_pclk  = pclk_q;
  assign cam.cam_vsync = vsync_q;
  assign cam.cam_href  = href_q;
  assign cam.cam_dout  = dout_q;
  assign frame_done    = frame_done_q;
  assign frame_count   = frame_count_q;
endmodule

// File: doc/camera_pattern_gen.md
# camera_pattern_gen

- Synthesizable stand-in for the parallel camera: drives the same vsync / href / pclk / 8-bit data bus that `camera_capture` consumes.
- Lets the capture → `shared_video_mem` → DVI path be brought up and regression-tested without a sensor on the header.
- Produces RGB565 test frames, two bytes per pixel, high byte first, with programmable frame geometry.
- A top-level mux selects between this block and the real header pins.

## Interface

Parameters:
- H_ACTIVE, 640: active pixels per line; must be a multiple of 8.
- H_BLANK, 144: blank byte slots per line, href low.
- V_ACTIVE, 480: active lines per frame.
- VSYNC_LINES, 3: lines with vsync high.
- V_BACK, 17: blank lines after vsync, before the first active line.
- V_FRONT, 10: blank lines after the last active line.

Ports:
- clk  in  1  system clock (clk_50 domain).
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  run request; level-sensitive.
- pattern_sel  in  2  pattern: 0 colour bars, 1 ramp, 2 checkerboard, 3 solid.
- solid_rgb  in  16  RGB565 colour used when pattern_sel is 3.
- cam_pclk  out  1  emulated pixel clock, clk/2, free-running.
- cam_vsync  out  1  frame sync, active high.
- cam_href  out  1  line valid, active high.
- cam_dout  out  8  pixel byte.
- frame_done  out  1  one-clk pulse at the end of each frame.
- frame_count  out  16  completed frames, wraps at 16'hFFFF to 0.

## Operation

- Line = L = 2*H_ACTIVE + H_BLANK byte slots; hcount counts 0..L-1 (11 bits).
- Frame = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT lines; vcount 10 bits.
- States:
  - IDLE: wait for enable.
  - VSYNC: cam_vsync=1 for VSYNC_LINES lines.
  - VBACK: V_BACK lines.
  - ACTIVE: V_ACTIVE lines.
  - VFRONT: V_FRONT lines.
- Transitions (evaluated only on slot edges):
  - IDLE → VSYNC when enable=1.
  - VSYNC → VBACK → ACTIVE → VFRONT, each after its line count.
  - At the end of VFRONT: → VSYNC if enable=1, else → IDLE.
- Deasserting enable mid-frame does not truncate the frame; the current frame always completes.
- pattern_sel and solid_rgb are latched on entry to VSYNC. They are constant for the whole frame.
- In ACTIVE, slots 0..2*H_ACTIVE-1 have cam_href=1. Pixel x = hcount>>1 and pixel y = active line index.
  - Even slot: cam_dout = pix[15:8].
  - Odd slot: cam_dout = pix[7:0].
- All other slots: cam_href=0 and cam_dout=0. cam_vsync is 1 only in VSYNC.
- Patterns:
  - 0, bars: 8 bars, each H_ACTIVE/8 pixels wide, left to right FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Use a bar counter; no divider.
  - 1, ramp: pix = {x[7:3], x[7:2], x[7:3]}.
  - 2, checker: pix = (x[3]^y[3]) ? FFFF : 0000.
  - 3, solid: pix = latched solid_rgb.
- frame_count increments, and frame_done pulses, on the slot edge that ends VFRONT.

## Timing

- cam_pclk is a register that toggles every clk, including in IDLE.
- Slot edge = the clk edge on which cam_pclk goes 1→0.
- cam_vsync, cam_href and cam_dout change only on slot edges. They are therefore stable across the cam_pclk rising edge on which the consumer samples.
- One byte per 2 clk; one pixel per 4 clk.
- Reset values (asynchronous, immediate on resetn=0): cam_pclk=0, cam_vsync=0, cam_href=0, cam_dout=0, frame_done=0, frame_count=0, state IDLE, counters 0. This also holds for reset asserted mid-frame.
- After resetn rises with enable=1:
  - cam_pclk rises on the 1st clk edge.
  - The first slot edge, on the 2nd clk edge, enters VSYNC: cam_vsync=1.
- First href rise occurs (VSYNC_LINES+V_BACK)*L slots after vsync rises.
- frame_done is high for exactly one clk, coincident with the last slot edge. With enable held, cam_vsync rises on that same edge, giving back-to-back frames with no gap.
- enable is sampled only on slot edges. A pulse shorter than 2 clk that misses a slot edge is ignored.

## Test plan

Small geometry for all cases: H_ACTIVE=16, H_BLANK=4, V_ACTIVE=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1. This gives L=36 slots and 252 slots (504 clk) per frame.

1. Reset, then enable=1, pattern 0 → vsync rises at clk 2 and is high 72 clk; first href high 144 clk after vsync rises, for 64 clk per line, 4 lines; pixel bytes FF,FF,FF,FF,FF,E0,FF,E0,07,FF… matching the bar table, sampled on pclk rise.
2. Pattern 3, solid_rgb=16'hA5C3 → every active byte pair is A5,C3. Changing solid_rgb mid-frame to 1234 has no effect until the next vsync.
3. Pattern 2 → line 0 pixels 0–7 are 0000 and pixels 8–15 are FFFF. Pattern 1 → pixel 15 = {5'd1, 6'd3, 5'd1} = 0861.
4. enable held for 3 frames → three frame_done pulses 504 clk apart; frame_count = 3; vsync re-rises on the same edge as each frame_done.
5. enable dropped mid-ACTIVE → current frame completes, then IDLE with vsync/href/dout 0 and pclk still toggling. Re-enabling starts a new frame at the next slot edge.
6. resetn pulled low mid-line with href=1 → all outputs and frame_count go to 0 without waiting for a clk edge. After release, the block restarts from IDLE.
